fetch_stage: RTL and testbench

//  IF stage plus IF/ID pipeline register of the 5-stage MIPS core; consumer of the hazard unit's

---
 rtl/fetch_stage_if.sv | 31 +++
 rtl/fetch_stage.sv | 140 ++++++++++++++
 tb/tb_fetch_stage.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: hazard-unit controls, ID redirect, instruction-memory port,
// IF/ID pipeline register outputs and the performance counters.
//   master : the fetch stage (drives imem_addr, if_id_*, counters)
//   slave  : the surrounding core / memory (drives controls, redirect, imem_rdata/ready)
interface fetch_stage_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
);
    logic              pc_write;
    logic              if_id_write;
    logic              flush;
    logic [DATA_W-1:0] redirect_pc;
    logic [DATA_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_rdata;
    logic              imem_ready;
    logic [DATA_W-1:0] if_id_instr;
    logic [DATA_W-1:0] if_id_pc4;
    logic              if_id_valid;
    logic [CNT_W-1:0]  stall_count;
    logic [CNT_W-1:0]  flush_count;

    modport master (
        input  pc_write, if_id_write, flush, redirect_pc, imem_rdata, imem_ready,
        output imem_addr, if_id_instr, if_id_pc4, if_id_valid, stall_count, flush_count
    );

    modport slave (
        output pc_write, if_id_write, flush, redirect_pc, imem_rdata, imem_ready,
        input  imem_addr, if_id_instr, if_id_pc4, if_id_valid, stall_count, flush_count
    );
endinterface

// File: rtl/fetch_stage.sv
// IF stage plus IF/ID pipeline register of the 5-stage MIPS core.
// Owns the PC, presents it as the instruction-memory address, bubbles IF/ID on
// memory wait states, honours hazard-unit stalls and ID-stage redirects, and keeps
// saturating stall/flush cycle counters.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high reset
//   bus   : fetch_stage_if.master (controls, redirect, imem port, IF/ID outputs, counters)
module fetch_stage #(
    parameter int unsigned       DATA_W   = 32,
    parameter logic [DATA_W-1:0] RESET_PC = DATA_W'(32'h0040_0000),
    parameter int unsigned       CNT_W    = 16
) (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.master bus
);

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        RUN      = 2'd1,
        WAIT_MEM = 2'd2,
        REDIRECT = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [DATA_W-1:0] pc4_q, pc4_d;
    logic              valid_q, valid_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic [DATA_W-1:0] pc_plus4;
    logic              active;
    logic              advance;

    assign pc_plus4 = pc_q + DATA_W'(4);
    assign active   = (state_q != BOOT);
    assign advance  = bus.pc_write && bus.imem_ready;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: BOOT lasts one cycle; afterwards flush wins, then memory wait
    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT: state_d = RUN;
            RUN, WAIT_MEM, REDIRECT: begin
                if (bus.flush) begin
                    state_d = REDIRECT;
                end else if (!bus.imem_ready) begin
                    state_d = WAIT_MEM;
                end else begin
                    state_d = RUN;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    // Datapath and counter next values: flush > hold > imem wait > advance
    always_comb begin
        pc_d        = pc_q;
        instr_d     = instr_q;
        pc4_d       = pc4_q;
        valid_d     = valid_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        if (!active) begin
            instr_d = '0;
            pc4_d   = '0;
            valid_d = 1'b0;
        end else if (bus.flush) begin
            pc_d    = bus.redirect_pc;
            instr_d = '0;
            pc4_d   = '0;
            valid_d = 1'b0;
        end else begin
            if (advance) begin
                pc_d = pc_plus4;
            end
            // A non-advancing PC will refetch, so a writable IF/ID takes a bubble
            if (bus.if_id_write) begin
                if (advance) begin
                    instr_d = bus.imem_rdata;
                    pc4_d   = pc_plus4;
                    valid_d = 1'b1;
                end else begin
                    instr_d = '0;
                    pc4_d   = '0;
                    valid_d = 1'b0;
                end
            end
        end

        if (active && !bus.flush && (!bus.pc_write || !bus.imem_ready)
            && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (active && bus.flush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q        <= RESET_PC;
            instr_q     <= '0;
            pc4_q       <= '0;
            valid_q     <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            pc4_q       <= pc4_d;
            valid_q     <= valid_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.imem_addr   = pc_q;
    assign bus.if_id_instr = instr_q;
    assign bus.if_id_pc4   = pc4_q;
    assign bus.if_id_valid = valid_q;
    assign bus.stall_count = stall_cnt_q;
    assign bus.flush_count = flush_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a table of per-cycle vectors for the main
// flow, plus hand-written sequences for reset mid-wait and counter saturation.
module tb_fetch_stage;

    logic clk;
    logic reset;
    logic reset4;

    fetch_stage_if #(.DATA_W(32), .CNT_W(16)) bus  ();
    fetch_stage_if #(.DATA_W(32), .CNT_W(4))  bus4 ();

    fetch_stage #(.DATA_W(32), .CNT_W(16)) dut  (.clk(clk), .reset(reset),  .bus(bus));
    fetch_stage #(.DATA_W(32), .CNT_W(4))  dut4 (.clk(clk), .reset(reset4), .bus(bus4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        pw;
        logic        iw;
        logic        fl;
        logic [31:0] rpc;
        logic        rdy;
        logic [31:0] rdata;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
        logic        e_valid;
        logic [15:0] e_stall;
        logic [15:0] e_flush;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic pw, input logic iw, input logic fl,
                                input logic [31:0] rpc, input logic rdy,
                                input logic [31:0] rdata, input logic [31:0] pc,
                                input logic [31:0] ins, input logic [31:0] p4,
                                input logic v, input logic [15:0] st,
                                input logic [15:0] fc);
        vec_t r;
        r.pw = pw; r.iw = iw; r.fl = fl; r.rpc = rpc; r.rdy = rdy; r.rdata = rdata;
        r.e_pc = pc; r.e_instr = ins; r.e_pc4 = p4; r.e_valid = v;
        r.e_stall = st; r.e_flush = fc;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic pw, input logic iw, input logic fl,
                         input logic [31:0] rpc, input logic rdy, input logic [31:0] rdata);
        bus.pc_write    = pw;
        bus.if_id_write = iw;
        bus.flush       = fl;
        bus.redirect_pc = rpc;
        bus.imem_ready  = rdy;
        bus.imem_rdata  = rdata;
    endtask

    task automatic drive4(input logic pw, input logic iw, input logic fl, input logic rdy);
        bus4.pc_write    = pw;
        bus4.if_id_write = iw;
        bus4.flush       = fl;
        bus4.redirect_pc = 32'h0040_0800;
        bus4.imem_ready  = rdy;
        bus4.imem_rdata  = 32'h0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // The hazard unit must never ask for PC advance while IF/ID is held
    always @(negedge clk) begin
        if (!reset) begin
            assert (!(bus.pc_write === 1'b1 && bus.if_id_write === 1'b0))
            else begin
                errors++;
                $display("FAIL illegal_hazard_combo pc_write=%b if_id_write=%b",
                         bus.pc_write, bus.if_id_write);
            end
        end
        if (!reset4) begin
            assert (!(bus4.pc_write === 1'b1 && bus4.if_id_write === 1'b0))
            else begin
                errors++;
                $display("FAIL illegal_hazard_combo4 pc_write=%b if_id_write=%b",
                         bus4.pc_write, bus4.if_id_write);
            end
        end
    end

    localparam logic [31:0] I0 = 32'h2001_0001;
    localparam logic [31:0] I1 = 32'h2002_0002;
    localparam logic [31:0] I2 = 32'h2003_0003;
    localparam logic [31:0] I3 = 32'h2004_0004;
    localparam logic [31:0] I4 = 32'h2005_0005;
    localparam logic [31:0] I5 = 32'h2006_0006;
    localparam logic [31:0] I6 = 32'h2007_0007;
    localparam logic [31:0] I7 = 32'h2008_0008;
    localparam logic [31:0] BAD = 32'hBAD0_0000;
    localparam logic [31:0] JNK = 32'hDEAD_BEEF;

    initial begin
        //            pw iw fl rpc           rdy rdata | pc            instr p4            v  st fc
        vecs[0]  = mk(1, 1, 1, 32'h1234_5678, 1, 32'hAAAA_0000, 32'h0040_0000, 0,  0,            0, 0, 0);
        vecs[1]  = mk(1, 1, 0, 0,             1, I0,  32'h0040_0004, I0, 32'h0040_0004, 1, 0, 0);
        vecs[2]  = mk(1, 1, 0, 0,             1, I1,  32'h0040_0008, I1, 32'h0040_0008, 1, 0, 0);
        vecs[3]  = mk(0, 0, 0, 0,             1, I2,  32'h0040_0008, I1, 32'h0040_0008, 1, 1, 0);
        vecs[4]  = mk(0, 0, 0, 0,             1, I2,  32'h0040_0008, I1, 32'h0040_0008, 1, 2, 0);
        vecs[5]  = mk(0, 0, 1, 32'h0040_0100, 1, JNK, 32'h0040_0100, 0,  0,            0, 2, 1);
        vecs[6]  = mk(1, 1, 0, 0,             1, I3,  32'h0040_0104, I3, 32'h0040_0104, 1, 2, 1);
        vecs[7]  = mk(1, 1, 0, 0,             0, BAD, 32'h0040_0104, 0,  0,            0, 3, 1);
        vecs[8]  = mk(1, 1, 0, 0,             0, BAD, 32'h0040_0104, 0,  0,            0, 4, 1);
        vecs[9]  = mk(1, 1, 0, 0,             0, BAD, 32'h0040_0104, 0,  0,            0, 5, 1);
        vecs[10] = mk(1, 1, 0, 0,             1, I4,  32'h0040_0108, I4, 32'h0040_0108, 1, 5, 1);
        vecs[11] = mk(0, 0, 0, 0,             0, BAD, 32'h0040_0108, I4, 32'h0040_0108, 1, 6, 1);
        vecs[12] = mk(1, 1, 1, 32'hFFFF_FFFC, 1, JNK, 32'hFFFF_FFFC, 0,  0,            0, 6, 2);
        vecs[13] = mk(1, 1, 0, 0,             1, I5,  32'h0000_0000, I5, 32'h0000_0000, 1, 6, 2);
        vecs[14] = mk(1, 1, 0, 0,             0, BAD, 32'h0000_0000, 0,  0,            0, 7, 2);
        vecs[15] = mk(1, 1, 1, 32'h0040_0200, 0, BAD, 32'h0040_0200, 0,  0,            0, 7, 3);
        vecs[16] = mk(1, 1, 0, 0,             1, I6,  32'h0040_0204, I6, 32'h0040_0204, 1, 7, 3);
        vecs[17] = mk(1, 1, 1, 32'h0040_0300, 1, JNK, 32'h0040_0300, 0,  0,            0, 7, 4);
        vecs[18] = mk(1, 1, 1, 32'h0040_0400, 1, JNK, 32'h0040_0400, 0,  0,            0, 7, 5);
        vecs[19] = mk(1, 1, 0, 0,             1, I7,  32'h0040_0404, I7, 32'h0040_0404, 1, 7, 5);

        reset  = 1'b1;
        reset4 = 1'b1;
        drive(1, 1, 0, 0, 1, 32'h0);
        drive4(1, 1, 0, 1);
        step();
        step();

        // Reset state
        chk("rst_pc",    bus.imem_addr, 32'h0040_0000);
        chk("rst_instr", bus.if_id_instr, 32'h0);
        chk("rst_pc4",   bus.if_id_pc4, 32'h0);
        chk("rst_valid", 32'(bus.if_id_valid), 32'h0);
        chk("rst_stall", 32'(bus.stall_count), 32'h0);
        chk("rst_flush", 32'(bus.flush_count), 32'h0);

        reset = 1'b0;
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].pw, vecs[i].iw, vecs[i].fl, vecs[i].rpc, vecs[i].rdy, vecs[i].rdata);
            step();
            chk($sformatf("v%0d_pc", i),    bus.imem_addr, vecs[i].e_pc);
            chk($sformatf("v%0d_instr", i), bus.if_id_instr, vecs[i].e_instr);
            chk($sformatf("v%0d_pc4", i),   bus.if_id_pc4, vecs[i].e_pc4);
            chk($sformatf("v%0d_valid", i), 32'(bus.if_id_valid), 32'(vecs[i].e_valid));
            chk($sformatf("v%0d_stall", i), 32'(bus.stall_count), 32'(vecs[i].e_stall));
            chk($sformatf("v%0d_flush", i), 32'(bus.flush_count), 32'(vecs[i].e_flush));
        end

        // Reset in the middle of a memory wait
        drive(1, 1, 0, 0, 0, BAD);
        step();
        chk("midwait_stall", 32'(bus.stall_count), 32'd8);
        reset = 1'b1;
        step();
        chk("midwait_rst_pc",    bus.imem_addr, 32'h0040_0000);
        chk("midwait_rst_valid", 32'(bus.if_id_valid), 32'h0);
        chk("midwait_rst_stall", 32'(bus.stall_count), 32'h0);
        chk("midwait_rst_flush", 32'(bus.flush_count), 32'h0);
        reset = 1'b0;
        drive(1, 1, 0, 0, 1, 32'h3000_0001);
        step();
        chk("reboot_pc",    bus.imem_addr, 32'h0040_0000);
        chk("reboot_valid", 32'(bus.if_id_valid), 32'h0);
        chk("reboot_stall", 32'(bus.stall_count), 32'h0);
        step();
        chk("reboot_adv_pc",    bus.imem_addr, 32'h0040_0004);
        chk("reboot_adv_instr", bus.if_id_instr, 32'h3000_0001);
        chk("reboot_adv_valid", 32'(bus.if_id_valid), 32'h1);

        // Counter saturation on the narrow-counter build
        reset4 = 1'b0;
        drive4(0, 0, 0, 1);
        step();
        chk("sat_boot_stall", 32'(bus4.stall_count), 32'h0);
        for (int i = 0; i < 14; i++) step();
        chk("sat_stall_14", 32'(bus4.stall_count), 32'hE);
        for (int i = 0; i < 6; i++) step();
        chk("sat_stall_20", 32'(bus4.stall_count), 32'hF);
        drive4(1, 1, 1, 1);
        for (int i = 0; i < 16; i++) step();
        chk("sat_flush_16",    32'(bus4.flush_count), 32'hF);
        chk("sat_stall_kept",  32'(bus4.stall_count), 32'hF);
        reset4 = 1'b1;
        step();
        chk("sat_rst_stall", 32'(bus4.stall_count), 32'h0);
        chk("sat_rst_flush", 32'(bus4.flush_count), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
